// File: rtl/param_decoder.sv
// Parameterized N-to-2^N one-hot decoder with a combinational output and a registered copy.
// Optional one-hot integrity checker enabled by defining PARAM_DECODER_ONEHOT_CHECK_EN.

`ifdef PARAM_DECODER_ONEHOT_CHECK_EN
module param_decoder_chk (
    input  logic clk,
    input  logic rst,
    input  logic viol
);
    // Simulation-only report of an integrity violation seen by the decoder.
    always @(posedge clk) begin
        if (!rst && viol) begin
            $error("param_decoder: one-hot integrity violation");
        end
    end
endmodule
`endif

module param_decoder #(
    parameter int N = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [N-1:0]        a,
    output logic [(2**N)-1:0]   y,
    output logic [(2**N)-1:0]   y_q,
    output logic [N-1:0]        idx_q,
    output logic                valid_q,
    output logic                err
);
    localparam int Y_WIDTH = 2**N;

    if (N < 1 || N > 16) begin : g_bad_n
        $error("param_decoder: N must be within 1..16");
    end

    logic [Y_WIDTH-1:0] y_s;
    logic [Y_WIDTH-1:0] y_q_r;
    logic [N-1:0]       idx_q_r;
    logic               valid_q_r;

    // Loop-compare decode: an unknown bit on a matches nothing, so y falls to zero.
    always_comb begin
        y_s = '0;
        for (int i = 0; i < Y_WIDTH; i++) begin
            if (a == i[N-1:0]) begin
                y_s[i] = 1'b1;
            end else begin
                y_s[i] = 1'b0;
            end
        end
    end

    // Capture the decode, its index and the sticky valid flag on enabled edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q_r     <= '0;
            idx_q_r   <= '0;
            valid_q_r <= 1'b0;
        end else if (en) begin
            y_q_r     <= y_s;
            idx_q_r   <= a;
            valid_q_r <= 1'b1;
        end else begin
            y_q_r     <= y_q_r;
            idx_q_r   <= idx_q_r;
            valid_q_r <= valid_q_r;
        end
    end

    assign y       = y_s;
    assign y_q     = y_q_r;
    assign idx_q   = idx_q_r;
    assign valid_q = valid_q_r;

`ifdef PARAM_DECODER_ONEHOT_CHECK_EN
    localparam logic [Y_WIDTH-1:0] ONE = {{(Y_WIDTH-1){1'b0}}, 1'b1};

    function automatic logic is_onehot(input logic [Y_WIDTH-1:0] v);
        return (v != '0) && ((v & (v - ONE)) == '0);
    endfunction

    logic viol_s;
    logic err_r;

    // Combine the free-running decode check with the registered-copy checks.
    always_comb begin
        viol_s = !is_onehot(y_s);
        if (valid_q_r) begin
            viol_s = viol_s || !is_onehot(y_q_r) || (y_q_r != (ONE << idx_q_r));
        end else begin
            viol_s = viol_s;
        end
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_r <= 1'b0;
        end else if (viol_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    assign err = err_r;

    param_decoder_chk u_chk (
        .clk  (clk),
        .rst  (rst),
        .viol (viol_s)
    );
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_param_decoder.sv
// Randomized self-checking bench for param_decoder at N=1, 3 and 5 against a
// behavioural power-of-two model.

module tb_param_decoder;
    logic clk = 1'b0;
    logic rst;
    logic en;

    logic [2:0]  a3;
    logic [7:0]  y3, yq3;
    logic [2:0]  idx3;
    logic        v3, e3;

    logic [0:0]  a1;
    logic [1:0]  y1, yq1;
    logic [0:0]  idx1;
    logic        v1, e1;

    logic [4:0]  a5;
    logic [31:0] y5, yq5;
    logic [4:0]  idx5;
    logic        v5, e5;

    int n_checks = 0;
    int n_errors = 0;

    longint m_yq3, m_yq1, m_yq5;
    int     m_idx3, m_idx1, m_idx5;
    bit     m_v3, m_v1, m_v5;

    param_decoder #(.N(3)) dut3 (.clk(clk), .rst(rst), .en(en), .a(a3), .y(y3), .y_q(yq3),
                                 .idx_q(idx3), .valid_q(v3), .err(e3));
    param_decoder #(.N(1)) dut1 (.clk(clk), .rst(rst), .en(en), .a(a1), .y(y1), .y_q(yq1),
                                 .idx_q(idx1), .valid_q(v1), .err(e1));
    param_decoder #(.N(5)) dut5 (.clk(clk), .rst(rst), .en(en), .a(a5), .y(y5), .y_q(yq5),
                                 .idx_q(idx5), .valid_q(v5), .err(e5));

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic longint pow2(input int k);
        longint r = 1;
        for (int i = 0; i < k; i++) r = r * 2;
        return r;
    endfunction

    task automatic model_reset();
        m_yq3 = 0; m_idx3 = 0; m_v3 = 1'b0;
        m_yq1 = 0; m_idx1 = 0; m_v1 = 1'b0;
        m_yq5 = 0; m_idx5 = 0; m_v5 = 1'b0;
    endtask

    task automatic model_edge();
        if (rst) begin
            model_reset();
        end else if (en) begin
            m_yq3 = pow2(int'(a3)); m_idx3 = int'(a3); m_v3 = 1'b1;
            m_yq1 = pow2(int'(a1)); m_idx1 = int'(a1); m_v1 = 1'b1;
            m_yq5 = pow2(int'(a5)); m_idx5 = int'(a5); m_v5 = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic check_all(input string tag);
        check_eq({tag, ".y3"},   64'(y3),   64'(pow2(int'(a3))));
        check_eq({tag, ".yq3"},  64'(yq3),  64'(m_yq3));
        check_eq({tag, ".idx3"}, 64'(idx3), 64'(m_idx3));
        check_eq({tag, ".v3"},   64'(v3),   64'(m_v3));
        check_eq({tag, ".e3"},   64'(e3),   64'd0);
        check_eq({tag, ".y1"},   64'(y1),   64'(pow2(int'(a1))));
        check_eq({tag, ".yq1"},  64'(yq1),  64'(m_yq1));
        check_eq({tag, ".idx1"}, 64'(idx1), 64'(m_idx1));
        check_eq({tag, ".v1"},   64'(v1),   64'(m_v1));
        check_eq({tag, ".y5"},   64'(y5),   64'(pow2(int'(a5))));
        check_eq({tag, ".yq5"},  64'(yq5),  64'(m_yq5));
        check_eq({tag, ".idx5"}, 64'(idx5), 64'(m_idx5));
        check_eq({tag, ".v5"},   64'(v5),   64'(m_v5));
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; a3 = 3'd0; a1 = 1'b0; a5 = 5'd0;
        model_reset();
        tick();
        tick();
        check_all("reset");

        // Combinational sweep, no loads.
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            a3 = 3'(i);
            a1 = 1'(i);
            a5 = (i == 7) ? 5'd31 : 5'(i);
            #1;
            check_all("sweep");
        end
        a3 = 3'd7;
        #1;
        check_eq("msb_y3", 64'(y3), 64'h80);

        // Load a=5 then hold for three edges while a moves.
        @(posedge clk); #1;
        en = 1'b1; a3 = 3'd5; a1 = 1'b1; a5 = 5'd31;
        tick();
        check_all("load");
        check_eq("load_yq3", 64'(yq3), 64'h20);
        check_eq("load_yq5", 64'(yq5), 64'h8000_0000);
        en = 1'b0; a3 = 3'd2; a1 = 1'b0; a5 = 5'd0;
        repeat (3) tick();
        check_all("hold");
        check_eq("hold_yq3", 64'(yq3), 64'h20);
        check_eq("hold_y3",  64'(y3),  64'h04);

        // Asynchronous reset between edges.
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_all("async_rst");
        a3 = 3'd6;
        #1;
        check_eq("rst_y3_tracks", 64'(y3), 64'h40);

        // Reset and load at the same edge: reset wins.
        @(posedge clk); #1;
        en = 1'b1; a3 = 3'd7;
        tick();
        check_all("rst_vs_en");
        check_eq("rst_vs_en_yq3", 64'(yq3), 64'h0);
        rst = 1'b0;
        tick();
        check_all("after_rst");
        check_eq("after_rst_yq3", 64'(yq3), 64'h80);

        // Randomized traffic with occasional resets.
        repeat (400) begin
            rst = ($urandom_range(0, 49) == 0);
            en  = 1'($urandom_range(0, 1));
            a3  = 3'($urandom);
            a1  = 1'($urandom);
            a5  = 5'($urandom);
            tick();
            check_all("rand");
        end
        rst = 1'b0;

`ifdef PARAM_DECODER_ONEHOT_CHECK_EN
        en = 1'b1; a3 = 3'd4;
        tick();
        en = 1'b0;
        force dut3.y_q_r = 8'h03;
        tick();
        check_eq("err_set", 64'(e3), 64'd1);
        release dut3.y_q_r;
        en = 1'b1; a3 = 3'd1;
        tick();
        tick();
        check_eq("err_sticky", 64'(e3), 64'd1);
        rst = 1'b1;
        tick();
        check_eq("err_clr", 64'(e3), 64'd0);
        rst = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
